// File: rtl/mult_arbiter.sv
// One signed multiplier shared by N_REQ requesters: round-robin grant, operands
// captured on the grant edge, shifted/truncated product returned two cycles later.
module mult_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 16,
    parameter int SHIFT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] a_flat,
    input  logic [N_REQ*W-1:0] b_flat,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   res_valid,
    output logic [W-1:0]       res,
    output logic [15:0]        stall_cnt
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef struct packed {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [PW-1:0] id;
    } op_t;

    logic [N_REQ-1:0][W-1:0] a_arr, b_arr;
    logic [PW-1:0]           ptr, gidx;
    logic                    found;
    op_t                     s1;
    logic                    s1_v;
    logic signed [2*W-1:0]   prod, prod_sh;

    assign a_arr = a_flat;
    assign b_arr = b_flat;

    // Rotating priority search starting at ptr; reset masks every grant.
    always_comb begin
        int idx;
        found = 1'b0;
        gidx  = '0;
        gnt   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req[PW'(idx)]) begin
                found = 1'b1;
                gidx  = PW'(idx);
            end
        end
        if (reset) found = 1'b0;
        if (found) gnt[gidx] = 1'b1;
    end

    always_comb begin
        prod    = $signed(s1.a) * $signed(s1.b);
        prod_sh = prod >>> SHIFT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            s1        <= '0;
            s1_v      <= 1'b0;
            res_valid <= '0;
            res       <= '0;
            stall_cnt <= '0;
        end else begin
            if (found) begin
                ptr   <= (gidx == PW'(N_REQ-1)) ? '0 : gidx + PW'(1);
                s1.a  <= a_arr[gidx];
                s1.b  <= b_arr[gidx];
                s1.id <= gidx;
            end
            s1_v      <= found;
            res_valid <= '0;
            // res only moves with a valid result, so it holds otherwise
            if (s1_v) begin
                res_valid[s1.id] <= 1'b1;
                res              <= prod_sh[W-1:0];
            end
            if (|(req & ~gnt) && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: single op, back-to-back signed ops, wrap,
// full contention, reset mid-operation and request withdrawal.
module tb_mult_arbiter;
    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_flat, b_flat;
    logic [N-1:0]   gnt, res_valid;
    logic [W-1:0]   res;
    logic [15:0]    stall_cnt;

    int checks = 0;
    int errors = 0;

    mult_arbiter #(.N_REQ(N), .W(W), .SHIFT(4)) dut (
        .clk(clk), .reset(reset), .req(req), .a_flat(a_flat), .b_flat(b_flat),
        .gnt(gnt), .res_valid(res_valid), .res(res), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        a_flat[i*W +: W] = a;
        b_flat[i*W +: W] = b;
    endtask

    initial begin
        logic [N-1:0] oh;
        reset = 1'b1; req = '0; a_flat = '0; b_flat = '0;
        tick();
        // reset masks grants even with every request up
        req = 4'b1111; #1;
        chk("gnt_in_reset", gnt, 4'b0000);
        tick();
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res", res, 0);
        chk("rst_stall", stall_cnt, 0);

        // C0..C3: one op per unit, back to back
        reset = 1'b0; req = 4'b0001; set_op(0, 16'd16, 16'd32); #1;
        chk("c0_gnt", gnt, 4'b0001);
        tick(); req = 4'b0010; set_op(1, -16'sd48, 16'sd5); #1;
        chk("c1_gnt", gnt, 4'b0010);
        chk("c1_rv", res_valid, 0);
        tick(); req = 4'b0100; set_op(2, -16'sd1, 16'sd1); #1;
        chk("c2_gnt", gnt, 4'b0100);
        chk("single_rv", res_valid, 4'b0001);
        chk("single_res", res, 16'd32);
        tick(); req = 4'b1000; set_op(3, 16'd32767, 16'd32767); #1;
        chk("c3_gnt", gnt, 4'b1000);
        chk("neg48_rv", res_valid, 4'b0010);
        chk("neg48_res", res, 16'hFFF1);
        tick(); req = 4'b0000; #1;
        chk("idle_gnt", gnt, 0);
        chk("neg1_rv", res_valid, 4'b0100);
        chk("neg1_res", res, 16'hFFFF);
        tick();
        // 0x3FFF0001 >>> 4 = 0x03FFF000, low 16 bits 0xF000
        chk("wrap_rv", res_valid, 4'b1000);
        chk("wrap_res", res, 16'hF000);
        tick();
        chk("hold_rv", res_valid, 0);
        chk("hold_res", res, 16'hF000);

        // full contention for 8 cycles, ptr back at 0
        for (int i = 0; i < N; i++) set_op(i, W'(16*(i+1)), 16'd16);
        for (int k = 0; k < 10; k++) begin
            req = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            oh = '0;
            if (k < 8) oh[k % 4] = 1'b1;
            chk($sformatf("rr_gnt_%0d", k), gnt, oh);
            if (k >= 2) begin
                oh = '0; oh[(k-2) % 4] = 1'b1;
                chk($sformatf("rr_rv_%0d", k), res_valid, oh);
                chk($sformatf("rr_res_%0d", k), res, 16*((k-2)%4+1));
            end
            tick();
        end
        chk("rr_stall", stall_cnt, 16'd8);
        chk("rr_rv_end", res_valid, 0);

        // reset one cycle after a grant drops the op and clears ptr
        set_op(0, 16'd16, 16'd32); set_op(2, -16'sd1, 16'sd1); set_op(3, 16'd32767, 16'd32767);
        req = 4'b0001; #1;
        chk("rm_gnt", gnt, 4'b0001);
        tick(); req = 4'b0000; reset = 1'b1;
        tick(); reset = 1'b0; req = 4'b0011; #1;
        chk("rm_no_rv", res_valid, 0);
        chk("rm_res_clr", res, 0);
        chk("rm_stall_clr", stall_cnt, 0);
        chk("rm_ptr0_gnt", gnt, 4'b0001);

        // ptr=1, unit 1 withdrawn: unit 2 wins, then ptr sits at 3
        tick(); req = 4'b0100; #1;
        chk("wd_gnt", gnt, 4'b0100);
        chk("wd_rv0", res_valid, 0);
        tick(); req = 4'b1001; #1;
        chk("wd_ptr3_gnt", gnt, 4'b1000);
        chk("wd_rv1", res_valid, 4'b0001);
        chk("wd_res1", res, 16'd32);
        tick(); req = 4'b0000; #1;
        chk("wd_rv2", res_valid, 4'b0100);
        chk("wd_res2", res, 16'hFFFF);
        tick();
        chk("wd_rv3", res_valid, 4'b1000);
        chk("wd_res3", res, 16'hF000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
